riscv_lsu_split: RTL and testbench
==================================

# riscv_lsu_split

Load-store unit between the core's execute stage and the word-organised data memory. Takes a byte/half/word request in the LDST_* size encoding and produces byte-enabled word transactions on the memory bus. Unlike the single-cycle LSU, it is a multicycle FSM that can split a misaligned access across two consecutive words, or flag it as an exception, as selected by parameter. It stalls the core until the access completes.

## Interface

- SPLIT_MISALIGNED, 1, 1: split misaligned accesses into two memory transactions; 0: raise misaligned_o and perform no access
- ADDR_WIDTH, 32, byte-address width; data width fixed at 32
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  memory instruction present in execute stage
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  LDST_B/H/W/BU/HU encoding
- core_addr_i  in  ADDR_WIDTH  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  load result, extended per size; valid while the RESP state is active
- core_stall_o  out  1  hold the core
- misaligned_o  out  1  misaligned access with SPLIT_MISALIGNED=0
- illegal_size_o  out  1  size code 3'b011, 3'b110 or 3'b111
- mem_req_o  out  1  memory transaction request
- mem_we_o  out  1  transaction is a write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- mem_wd_o  out  32  write data, lane-aligned
- mem_rd_i  in  32  read data, valid when mem_ready_i=1
- mem_ready_i  in  1  current transaction completes this cycle

## Operation

- States: IDLE, ACC0, ACC1, RESP.
- n = 1/2/4 bytes for B,BU / H,HU / W. Stores treat BU as B and HU as H. off = addr[1:0]. An access is misaligned when off+n > 4.
- IDLE: core_req_i=1 with a legal, allowed request → latch we, size, addr and wd; go to ACC0. In this cycle core_stall_o=1. Illegal size or disallowed misaligned request → pulse the matching error output combinationally, core_stall_o=0, no transition, no memory access.
- ACC0: mem_req_o=1, mem_addr_o = {addr[AW-1:2],2'b00}, mem_be_o = (mask_n << off)[3:0], mem_wd_o = (wd << 8·off)[31:0]. mask_n is 4'b0001, 4'b0011 or 4'b1111. On mem_ready_i: capture mem_rd_i into rd0, then go to ACC1 if misaligned, else RESP.
- ACC1: mem_addr_o = word address + 4, modulo 2^ADDR_WIDTH (wraps to 0). mem_be_o = (mask_n << off)[7:4], mem_wd_o = (wd << 8·off)[63:32]. On mem_ready_i: capture rd1 and go to RESP.
- RESP: core_rd_o = ({rd1,rd0} >> 8·off), truncated to n bytes. B and H are sign-extended; BU and HU are zero-extended; W is unmodified. For stores core_rd_o = 0. core_stall_o=0. Next state is always IDLE.
- mem_req_o and all other mem_* outputs are held stable while waiting for mem_ready_i. mem_req_o=0 outside ACC0/ACC1, and mem_be_o=0 there.
- core_stall_o = core_req_i & ~(state==RESP) & ~error. A new request is sampled only in IDLE, one cycle after RESP.

## Timing

- Reset (asynchronous, immediate): state=IDLE, rd0=rd1=0, every output 0.
- Aligned access, zero-wait memory: 3 cycles (IDLE, ACC0, RESP). Split access: 4 cycles. Each wait cycle (mem_ready_i=0) adds one cycle.
- Reset asserted during ACC0 or ACC1: mem_req_o drops in the same cycle. The partial split store is not rolled back; the bench accepts that first-word bytes were written.
- core_req_i dropping mid-access does not abort the access. The FSM still completes through RESP.
- Error outputs are combinational in IDLE only; they are 0 in every other state.

## Test plan

- Aligned LW addr=0x100, memory returns 0xDEADBEEF with ready on first cycle → mem_addr_o=0x100, be=4'b1111, stall high 2 cycles, core_rd_o=0xDEADBEEF in RESP.
- LB addr=0x103, mem_rd_i=0x80xxxxxx → be=4'b1000, core_rd_o=0xFFFFFF80. LBU at the same address → 0x00000080.
- SW addr=0x102 wd=0x11223344, SPLIT=1 → ACC0: addr 0x100, be=4'b1100, wd=0x33440000. ACC1: addr 0x104, be=4'b0011, wd=0x00001122. Total 4 cycles.
- LH addr=0xFFFFFFFF, SPLIT=1, words 0xAB000000 then 0x000000CD → second address 0x00000000, core_rd_o=0xFFFFCDAB.
- SPLIT=0, LW addr=0x101 → misaligned_o=1 and stall=0 in the same cycle, mem_req_o never asserted. size=3'b111 → illegal_size_o=1.
- Misaligned load with mem_ready_i held low 3 cycles in ACC1, then rst_ni pulsed → mem_req_o stable through the wait, then 0 immediately on reset; after release, state IDLE and all outputs 0.

Source files
------------

// File: rtl/riscv_lsu_split.sv
// riscv_lsu_split: multicycle load-store unit that turns byte/half/word core requests
// into byte-enabled word transactions, splitting misaligned accesses over two words
// (SPLIT_MISALIGNED=1) or flagging them (SPLIT_MISALIGNED=0).
// Ports: clk_i/rst_ni clock and async active-low reset; core_* execute-stage request,
// store data, load result and stall; misaligned_o/illegal_size_o request errors (IDLE only);
// mem_* word-organised memory bus with mem_ready_i completing a transaction.
module riscv_lsu_split #(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [2:0]            core_size_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [31:0]           core_wd_i,
    output logic [31:0]           core_rd_o,
    output logic                  core_stall_o,
    output logic                  misaligned_o,
    output logic                  illegal_size_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wd_o,
    input  logic [31:0]           mem_rd_i,
    input  logic                  mem_ready_i
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                state, state_nx;
    logic                  we_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wd_q, rd0, rd1;

    // size[1:0] alone selects the width; the unsigned codes share it with their signed twins
    function automatic logic [3:0] size_mask(input logic [1:0] s);
        return s == 2'b00 ? 4'b0001 : s == 2'b01 ? 4'b0011 : 4'b1111;
    endfunction

    function automatic logic crosses_word(input logic [1:0] s, input logic [1:0] off);
        return s == 2'b01 ? off == 2'd3 : s == 2'b10 ? off != 2'd0 : 1'b0;
    endfunction

    logic                  req_illegal, req_mis, idle_req, err, mis_q;
    logic [1:0]            off;
    logic [7:0]            be_span;
    logic [63:0]           wd_span;
    logic [31:0]           rd_sh;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign req_illegal    = core_size_i[1:0] == 2'b11 || core_size_i == 3'b110;
    assign req_mis        = crosses_word(core_size_i[1:0], core_addr_i[1:0]);
    assign idle_req       = state == IDLE && core_req_i;
    assign illegal_size_o = idle_req && req_illegal;
    assign misaligned_o   = idle_req && !req_illegal && req_mis && !SPLIT_MISALIGNED;
    assign err            = illegal_size_o || misaligned_o;
    assign core_stall_o   = core_req_i && state != RESP && !err;

    assign off       = addr_q[1:0];
    assign mis_q     = crosses_word(size_q[1:0], off);
    assign be_span   = {4'b0000, size_mask(size_q[1:0])} << off;
    assign wd_span   = {32'h0, wd_q} << {off, 3'b000};
    assign rd_sh     = 32'({rd1, rd0} >> {off, 3'b000});
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // the upper half of each span belongs to the following word
    assign mem_req_o  = state == ACC0 || state == ACC1;
    assign mem_we_o   = mem_req_o && we_q;
    assign mem_be_o   = state == ACC0 ? be_span[3:0] : state == ACC1 ? be_span[7:4] : 4'b0000;
    assign mem_addr_o = state == ACC0 ? word_addr :
                        state == ACC1 ? word_addr + ADDR_WIDTH'(4) : '0;
    assign mem_wd_o   = state == ACC0 ? wd_span[31:0] : state == ACC1 ? wd_span[63:32] : 32'h0;

    always_comb begin
        core_rd_o = 32'h0;
        if (state == RESP && !we_q)
            core_rd_o = size_q == 3'b000 ? {{24{rd_sh[7]}}, rd_sh[7:0]} :
                        size_q == 3'b001 ? {{16{rd_sh[15]}}, rd_sh[15:0]} :
                        size_q == 3'b100 ? {24'h0, rd_sh[7:0]} :
                        size_q == 3'b101 ? {16'h0, rd_sh[15:0]} : rd_sh;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = core_req_i && !err ? ACC0 : IDLE;
            ACC0: state_nx = !mem_ready_i ? ACC0 : mis_q ? ACC1 : RESP;
            ACC1: state_nx = mem_ready_i ? RESP : ACC1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            size_q <= 3'b000;
            addr_q <= '0;
            wd_q   <= 32'h0;
            rd0    <= 32'h0;
            rd1    <= 32'h0;
        end else begin
            state <= state_nx;
            if (idle_req && !err) begin
                we_q   <= core_we_i;
                size_q <= core_size_i;
                addr_q <= core_addr_i;
                wd_q   <= core_wd_i;
            end
            if (state == ACC0 && mem_ready_i) rd0 <= mem_rd_i;
            if (state == ACC1 && mem_ready_i) rd1 <= mem_rd_i;
        end
    end
endmodule

// File: tb/tb_riscv_lsu_split.sv
// tb_riscv_lsu_split: randomized and directed checks of riscv_lsu_split against a byte-level memory model.
module tb_riscv_lsu_split;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        core_req = 1'b0, core_we = 1'b0;
    logic [2:0]  core_size = 3'b000;
    logic [31:0] core_addr = 32'h0, core_wd = 32'h0;
    logic [31:0] core_rd, mem_addr, mem_wd;
    logic [31:0] mem_rd = 32'h0;
    logic        core_stall, mis, ill, mem_req, mem_we;
    logic        mem_ready = 1'b0;
    logic [3:0]  mem_be;

    logic        n_req = 1'b0;
    logic [31:0] n_rd, n_addr, n_wd;
    logic [31:0] n_mem_rd = 32'h0;
    logic        n_ready = 1'b1;
    logic        n_stall, n_mis, n_ill, n_mreq, n_mwe;
    logic [3:0]  n_be;

    riscv_lsu_split #(.SPLIT_MISALIGNED(1'b1), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(core_req), .core_we_i(core_we),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(core_rd), .core_stall_o(core_stall), .misaligned_o(mis),
        .illegal_size_o(ill), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    riscv_lsu_split #(.SPLIT_MISALIGNED(1'b0), .ADDR_WIDTH(32)) dut_ns (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(n_req), .core_we_i(core_we),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(n_rd), .core_stall_o(n_stall), .misaligned_o(n_mis),
        .illegal_size_o(n_ill), .mem_req_o(n_mreq), .mem_we_o(n_mwe), .mem_be_o(n_be),
        .mem_addr_o(n_addr), .mem_wd_o(n_wd), .mem_rd_i(n_mem_rd), .mem_ready_i(n_ready)
    );

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    int n_cmp = 0, n_fail = 0;

    logic [7:0] dut_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } tx_t;
    tx_t txq[$];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] dut_byte(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic int nbytes(input logic [2:0] s);
        return (s == LB || s == LBU) ? 1 : (s == LH || s == LHU) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(s); i++) v[8*i +: 8] = ref_byte(a + 32'(i));
        if (s == LB) v = 32'($signed(v[7:0]));
        if (s == LH) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    // Byte i of the store data lands at byte address a+i; only the first n bytes are enabled.
    function automatic void exp_tx(input logic [2:0] s, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] wa, output logic [3:0] be, output logic [31:0] w);
        logic [31:0] ba;
        be = 4'b0000;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ba = a + 32'(i);
            if ((ba & ~32'd3) == wa) begin
                w[8*ba[1:0] +: 8] = wd[8*i +: 8];
                if (i < nbytes(s)) be[ba[1:0]] = 1'b1;
            end
        end
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            dut_mem[a + 32'(i)] = w[8*i +: 8];
            ref_mem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    task automatic ref_store(input logic [2:0] s, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(s); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    // Memory responder: decides ready at the falling edge so the DUT sees it at the next rising edge.
    int w0 = 0, w1 = 0, tx_idx = 0, wcnt = 0;
    always @(negedge clk) begin
        if (!mem_req) begin
            tx_idx = 0;
            wcnt = 0;
            mem_ready = 1'b0;
        end else if (wcnt >= (tx_idx == 0 ? w0 : w1)) begin
            mem_ready = 1'b1;
            wcnt = 0;
            tx_idx++;
            txq.push_back('{mem_addr, mem_be, mem_wd, mem_we});
            if (mem_we)
                for (int l = 0; l < 4; l++)
                    if (mem_be[l]) dut_mem[mem_addr + 32'(l)] = mem_wd[8*l +: 8];
        end else begin
            mem_ready = 1'b0;
            wcnt++;
        end
        mem_rd = {dut_byte(mem_addr + 32'd3), dut_byte(mem_addr + 32'd2),
                  dut_byte(mem_addr + 32'd1), dut_byte(mem_addr)};
    end

    task automatic do_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input int a0, input int a1,
                         output logic [31:0] rd, output int cycles);
        w0 = a0;
        w1 = a1;
        txq.delete();
        rd = 32'h0;
        cycles = -1;
        @(negedge clk);
        core_req = 1'b1;
        core_we = we;
        core_size = size;
        core_addr = addr;
        core_wd = wd;
        for (int c = 1; c <= 64; c++) begin
            #1;
            if (!core_stall) begin
                rd = core_rd;
                cycles = c;
                break;
            end
            @(negedge clk);
        end
        core_req = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({core_rd, core_stall, mis, ill, mem_req, mem_we, mem_be, mem_addr, mem_wd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rd=%h stall=%b req=%b be=%h addr=%h exp all zero",
                     core_rd, core_stall, mem_req, mem_be, mem_addr);
        end
        n_cmp++;
        if ({n_rd, n_stall, n_mis, n_ill, n_mreq, n_mwe, n_be, n_addr, n_wd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_nosplit got nonzero output exp all zero");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw_aligned;
        logic [31:0] rd;
        int cyc;
        poke(32'h100, 32'hDEADBEEF);
        do_op(1'b0, LW, 32'h100, 32'h0, 0, 0, rd, cyc);
        n_cmp++;
        if (cyc !== 3) begin n_fail++; $display("FAIL lw_cycles got=%0d exp=3", cyc); end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rd got=%h exp=deadbeef", rd); end
        n_cmp++;
        if (txq.size() !== 1) begin n_fail++; $display("FAIL lw_ntx got=%0d exp=1", txq.size()); end
        else begin
            n_cmp++;
            if (txq[0].addr !== 32'h100 || txq[0].be !== 4'b1111 || txq[0].we !== 1'b0) begin
                n_fail++;
                $display("FAIL lw_tx got addr=%h be=%b we=%b exp addr=100 be=1111 we=0",
                         txq[0].addr, txq[0].be, txq[0].we);
            end
        end
    endtask

    task automatic test_lb_sign;
        logic [31:0] rd;
        int cyc;
        poke(32'h100, 32'h80123456);
        do_op(1'b0, LB, 32'h103, 32'h0, 0, 0, rd, cyc);
        n_cmp++;
        if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rd got=%h exp=ffffff80", rd); end
        n_cmp++;
        if (txq.size() !== 1 || txq[0].be !== 4'b1000 || txq[0].addr !== 32'h100) begin
            n_fail++;
            $display("FAIL lb_tx got ntx=%0d exp ntx=1 be=1000 addr=100", txq.size());
        end
        do_op(1'b0, LBU, 32'h103, 32'h0, 0, 0, rd, cyc);
        n_cmp++;
        if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rd got=%h exp=00000080", rd); end
    endtask

    task automatic test_sw_split;
        logic [31:0] rd, got;
        int cyc;
        do_op(1'b1, LW, 32'h102, 32'h11223344, 0, 0, rd, cyc);
        ref_store(LW, 32'h102, 32'h11223344);
        n_cmp++;
        if (cyc !== 4) begin n_fail++; $display("FAIL sw_cycles got=%0d exp=4", cyc); end
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rd got=%h exp=0", rd); end
        n_cmp++;
        if (txq.size() !== 2) begin n_fail++; $display("FAIL sw_ntx got=%0d exp=2", txq.size()); end
        else begin
            n_cmp++;
            if (txq[0].addr !== 32'h100 || txq[0].be !== 4'b1100 || txq[0].wd !== 32'h33440000 || txq[0].we !== 1'b1) begin
                n_fail++;
                $display("FAIL sw_tx0 got addr=%h be=%b wd=%h exp addr=100 be=1100 wd=33440000",
                         txq[0].addr, txq[0].be, txq[0].wd);
            end
            n_cmp++;
            if (txq[1].addr !== 32'h104 || txq[1].be !== 4'b0011 || txq[1].wd !== 32'h00001122 || txq[1].we !== 1'b1) begin
                n_fail++;
                $display("FAIL sw_tx1 got addr=%h be=%b wd=%h exp addr=104 be=0011 wd=00001122",
                         txq[1].addr, txq[1].be, txq[1].wd);
            end
        end
        got = {dut_byte(32'h105), dut_byte(32'h104), dut_byte(32'h103), dut_byte(32'h102)};
        n_cmp++;
        if (got !== 32'h11223344) begin n_fail++; $display("FAIL sw_mem got=%h exp=11223344", got); end
    endtask

    task automatic test_lh_wrap;
        logic [31:0] rd;
        int cyc;
        poke(32'hFFFFFFFC, 32'hAB000000);
        poke(32'h00000000, 32'h000000CD);
        do_op(1'b0, LH, 32'hFFFFFFFF, 32'h0, 0, 0, rd, cyc);
        n_cmp++;
        if (rd !== 32'hFFFFCDAB) begin n_fail++; $display("FAIL lh_wrap_rd got=%h exp=ffffcdab", rd); end
        n_cmp++;
        if (txq.size() !== 2) begin n_fail++; $display("FAIL lh_wrap_ntx got=%0d exp=2", txq.size()); end
        else begin
            n_cmp++;
            if (txq[0].addr !== 32'hFFFFFFFC || txq[1].addr !== 32'h0) begin
                n_fail++;
                $display("FAIL lh_wrap_addr got=%h,%h exp=fffffffc,00000000", txq[0].addr, txq[1].addr);
            end
        end
        n_cmp++;
        if (cyc !== 4) begin n_fail++; $display("FAIL lh_wrap_cycles got=%0d exp=4", cyc); end
    endtask

    task automatic test_errors;
        logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
        logic [31:0] a;
        logic [2:0] s;
        logic [2:0] legal [5] = '{LB, LH, LW, LBU, LHU};
        logic exp_mis;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            core_req = 1'b1;
            core_we = 1'(k & 1);
            core_size = bad[k];
            core_addr = 32'h200;
            #1;
            n_cmp++;
            if ({ill, mis, core_stall, mem_req} !== 4'b1000) begin
                n_fail++;
                $display("FAIL illegal_size_%b got ill/mis/stall/req=%b exp=1000", bad[k], {ill, mis, core_stall, mem_req});
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (mem_req !== 1'b0) begin n_fail++; $display("FAIL illegal_noaccess got=%b exp=0", mem_req); end
            core_req = 1'b0;
        end
        @(negedge clk);
        core_we = 1'b0;
        core_size = LW;
        core_addr = 32'h101;
        n_req = 1'b1;
        #1;
        n_cmp++;
        if ({n_mis, n_ill, n_stall, n_mreq} !== 4'b1000) begin
            n_fail++;
            $display("FAIL nosplit_lw101 got mis/ill/stall/req=%b exp=1000", {n_mis, n_ill, n_stall, n_mreq});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (n_mreq !== 1'b0) begin n_fail++; $display("FAIL nosplit_noaccess got=%b exp=0", n_mreq); end
        n_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s = legal[$urandom_range(0, 4)];
            a = $urandom;
            exp_mis = (int'(a[1:0]) + nbytes(s)) > 4;
            core_size = s;
            core_addr = a;
            core_we = 1'($urandom_range(0, 1));
            n_req = 1'b1;
            #1;
            n_cmp++;
            if ({n_mis, n_stall, n_ill} !== {exp_mis, !exp_mis, 1'b0}) begin
                n_fail++;
                $display("FAIL nosplit_rand size=%b addr=%h got mis/stall/ill=%b exp=%b",
                         s, a, {n_mis, n_stall, n_ill}, {exp_mis, !exp_mis, 1'b0});
            end
            @(negedge clk);
            n_req = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [71:0] snap;
        logic [31:0] rd;
        int cyc;
        w0 = 0;
        w1 = 1000;
        txq.delete();
        @(negedge clk);
        core_req = 1'b1;
        core_we = 1'b0;
        core_size = LW;
        core_addr = 32'h101;
        core_wd = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        #1;
        snap = {mem_req, mem_we, mem_be, mem_addr, mem_wd, 2'b00};
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_be !== 4'b0001) begin
            n_fail++;
            $display("FAIL acc1_wait got req=%b addr=%h be=%b exp req=1 addr=104 be=0001", mem_req, mem_addr, mem_be);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, 2'b00} !== snap) begin
                n_fail++;
                $display("FAIL wait_stable_%0d got addr=%h be=%b exp addr=%h be=%b", k, mem_addr, mem_be, snap[65:34], snap[69:66]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, mem_be, mem_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_drop got req=%b be=%b addr=%h exp all zero", mem_req, mem_be, mem_addr);
        end
        core_req = 1'b0;
        #1;
        n_cmp++;
        if ({core_rd, core_stall, mis, ill, mem_req, mem_we, mem_be, mem_addr, mem_wd} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got stall=%b req=%b rd=%h exp all zero", core_stall, mem_req, core_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({core_rd, core_stall, mis, ill, mem_req, mem_we, mem_be, mem_addr, mem_wd} !== '0) begin
            n_fail++;
            $display("FAIL after_release got stall=%b req=%b exp all zero", core_stall, mem_req);
        end
        poke(32'h200, 32'h0BADC0DE);
        do_op(1'b0, LW, 32'h200, 32'h0, 0, 0, rd, cyc);
        n_cmp++;
        if (rd !== 32'h0BADC0DE || cyc !== 3) begin
            n_fail++;
            $display("FAIL after_reset_op got rd=%h cyc=%0d exp rd=0badc0de cyc=3", rd, cyc);
        end
    endtask

    task automatic test_random;
        logic [2:0] legal [5] = '{LB, LH, LW, LBU, LHU};
        logic [2:0] s;
        logic [31:0] a, wd, rd, exp_rd, wa, ew;
        logic [3:0] eb;
        logic [63:0] got_m, exp_m;
        logic we;
        int a0, a1, cyc, ntx, exp_cyc;
        for (int k = 0; k < 40; k++) begin
            s = legal[$urandom_range(0, 4)];
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            a0 = $urandom_range(0, 2);
            a1 = $urandom_range(0, 2);
            ntx = (int'(a[1:0]) + nbytes(s)) > 4 ? 2 : 1;
            exp_rd = we ? 32'h0 : ref_load(s, a);
            exp_cyc = 3 + a0 + (ntx == 2 ? 1 + a1 : 0);
            do_op(we, s, a, wd, a0, a1, rd, cyc);
            n_cmp++;
            if (cyc !== exp_cyc) begin
                n_fail++;
                $display("FAIL rand%0d_cycles got=%0d exp=%0d", k, cyc, exp_cyc);
            end
            n_cmp++;
            if (rd !== exp_rd) begin
                n_fail++;
                $display("FAIL rand%0d_rd we=%b size=%b addr=%h got=%h exp=%h", k, we, s, a, rd, exp_rd);
            end
            n_cmp++;
            if (txq.size() !== ntx) begin
                n_fail++;
                $display("FAIL rand%0d_ntx got=%0d exp=%0d", k, txq.size(), ntx);
            end else begin
                for (int t = 0; t < ntx; t++) begin
                    wa = (a & ~32'd3) + 32'(4 * t);
                    exp_tx(s, a, wd, wa, eb, ew);
                    n_cmp++;
                    if (txq[t].addr !== wa || txq[t].be !== eb || txq[t].wd !== ew || txq[t].we !== we) begin
                        n_fail++;
                        $display("FAIL rand%0d_tx%0d got addr=%h be=%b wd=%h we=%b exp addr=%h be=%b wd=%h we=%b",
                                 k, t, txq[t].addr, txq[t].be, txq[t].wd, txq[t].we, wa, eb, ew, we);
                    end
                end
            end
            if (we) begin
                ref_store(s, a, wd);
                for (int i = 0; i < 8; i++) begin
                    got_m[8*i +: 8] = dut_byte((a & ~32'd3) + 32'(i));
                    exp_m[8*i +: 8] = ref_byte((a & ~32'd3) + 32'(i));
                end
                n_cmp++;
                if (got_m !== exp_m) begin
                    n_fail++;
                    $display("FAIL rand%0d_mem size=%b addr=%h got=%h exp=%h", k, s, a, got_m, exp_m);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw_aligned();
        test_lb_sign();
        test_sw_split();
        test_lh_wrap();
        test_errors();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
